// File: rtl/adc_range_sequencer.sv
// adc_range_sequencer
// Drives an external range checker through a fixed scan of WORD_COUNT words.
// For each word it issues one command strobe (latch for word 0, shift for the
// rest), waits SETTLE_CYCLES, then captures the 16-bit signed readout into the
// back half of a ping-pong buffer. At the end of a scan the halves swap, so the
// read port always shows a complete, coherent scan. Captures are also tested
// against a magnitude threshold to raise sticky per-sample alarms: word 2k is
// the min of sample k, word 2k+1 the max.
//
// Ports
//   sysClk, sysReset  : clock, synchronous active-high reset
//   sysCsrStrobe      : control write strobe, data on GPIO_OUT
//   GPIO_OUT          : [0] start, [1] periodic enable, [2] clear alarms,
//                       [31:8] holdoff period in cycles
//   sysStatus         : [31:16] scan count, [2] front bank, [1] periodic, [0] busy
//   rangeCsrStrobe    : one-cycle command strobe to the range checker
//   rangeGpioOut      : checker command, [0] latch, [1] shift
//   rangeReadout      : checker readout, signed value in [15:0]
//   sysReadAddress    : front-bank word select
//   sysReadData       : front-bank word, registered (1-cycle latency)
//   alarmThreshold    : unsigned magnitude threshold
//   sysAlarms         : sticky over-range flags, one per sample
module adc_range_sequencer #(
   parameter  int WORD_COUNT    = 8,
   parameter  int SETTLE_CYCLES = 8,
   localparam int AW            = $clog2(WORD_COUNT),
   localparam int NS            = WORD_COUNT / 2
) (
   input  logic          sysClk,
   input  logic          sysReset,
   input  logic          sysCsrStrobe,
   input  logic [31:0]   GPIO_OUT,
   output logic [31:0]   sysStatus,
   output logic          rangeCsrStrobe,
   output logic [31:0]   rangeGpioOut,
   input  logic [31:0]   rangeReadout,
   input  logic [AW-1:0] sysReadAddress,
   output logic [15:0]   sysReadData,
   input  logic [15:0]   alarmThreshold,
   output logic [NS-1:0] sysAlarms
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      SETTLE,
      CAPTURE,
      DONE,
      HOLDOFF
   } state_t;

   state_t state, state_nx;

   logic [AW-1:0]    idx;
   logic [7:0]       settle_cnt;
   logic [23:0]      hold_cnt;
   logic [23:0]      period;
   logic             periodic;
   logic             front;
   logic [15:0]      scan_count;
   logic [NS-1:0]    alarms;
   logic [15:0]      bank [2][WORD_COUNT];

   logic             ctrl_start;
   logic             ctrl_clear;
   logic             last_word;
   logic             settle_done;
   logic             hold_done;

   logic [15:0]      sample;
   logic signed [16:0] sample_s;
   logic signed [16:0] thr_s;
   logic             alarm_hit;
   logic [AW-1:0]    slot;
   logic [NS-1:0]    alarm_set;

   logic             unused_bits;

   assign unused_bits = ^{GPIO_OUT[7:3], rangeReadout[31:16]};

   assign ctrl_start  = sysCsrStrobe & GPIO_OUT[0];
   assign ctrl_clear  = sysCsrStrobe & GPIO_OUT[2];
   assign last_word   = (idx == AW'(WORD_COUNT - 1));
   assign settle_done = (settle_cnt == 8'(SETTLE_CYCLES - 1));
   // ">=" rather than "==" so a period rewritten below the running count
   // releases the holdoff instead of waiting for the counter to wrap.
   assign hold_done   = (({1'b0, hold_cnt} + 25'd1) >= {1'b0, period});

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (ctrl_start) state_nx = REQ;
         REQ:     state_nx = SETTLE;
         SETTLE:  if (settle_done) state_nx = CAPTURE;
         CAPTURE: state_nx = last_word ? DONE : REQ;
         DONE: begin
            if (!periodic)
               state_nx = IDLE;
            else if (period == 24'd0)
               state_nx = REQ;         // zero holdoff: next scan starts at once
            else
               state_nx = HOLDOFF;
         end
         HOLDOFF: begin
            if (!periodic)
               state_nx = IDLE;
            else if (hold_done)
               state_nx = REQ;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Checker command is decoded straight from the state register, so it is
   // glitch-free and drops to zero on the edge after reset.
   always_comb begin
      rangeCsrStrobe = 1'b0;
      rangeGpioOut   = '0;
      if (state == REQ) begin
         rangeCsrStrobe  = 1'b1;
         rangeGpioOut[0] = (idx == '0);
         rangeGpioOut[1] = (idx != '0);
      end
   end

   // ---------------------------------------------------------------------
   // Alarm compare: 17-bit signed so that threshold 0xFFFF negates cleanly
   // ---------------------------------------------------------------------
   always_comb begin
      sample    = rangeReadout[15:0];
      sample_s  = {sample[15], sample};
      thr_s     = {1'b0, alarmThreshold};
      alarm_hit = idx[0] ? (sample_s > thr_s) : (sample_s < -thr_s);
      slot      = idx >> 1;
      alarm_set = '0;
      for (int s = 0; s < NS; s++) begin
         if ((state == CAPTURE) && alarm_hit && (slot == AW'(s)))
            alarm_set[s] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Control and sequencing registers
   // ---------------------------------------------------------------------
   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         state       <= IDLE;
         idx         <= '0;
         settle_cnt  <= '0;
         hold_cnt    <= '0;
         periodic    <= 1'b0;
         period      <= '0;
         front       <= 1'b0;
         scan_count  <= '0;
         alarms      <= '0;
         sysReadData <= '0;
      end else begin
         state <= state_nx;

         if (sysCsrStrobe) begin
            periodic <= GPIO_OUT[1];
            period   <= GPIO_OUT[31:8];
         end

         // A capture that trips in the same cycle as a clear still sticks.
         alarms <= (ctrl_clear ? '0 : alarms) | alarm_set;

         settle_cnt <= (state == SETTLE)  ? settle_cnt + 8'd1 : 8'd0;
         hold_cnt   <= (state == HOLDOFF) ? hold_cnt + 24'd1  : 24'd0;

         if (state == CAPTURE)
            idx <= last_word ? '0 : idx + AW'(1);

         if (state == DONE) begin
            front      <= ~front;
            scan_count <= scan_count + 16'd1;
         end

         sysReadData <= bank[front][sysReadAddress];
      end
   end

   // Ping-pong storage. Only the back half is ever written, so the read
   // port never sees a partially captured scan. No reset on the array.
   always_ff @(posedge sysClk) begin
      if (!sysReset && (state == CAPTURE))
         bank[~front][idx] <= sample;
   end

   assign sysStatus = {scan_count, 13'd0, front, periodic, (state != IDLE)};
   assign sysAlarms = alarms;

endmodule

// File: tb/tb_adc_range_sequencer.sv
module tb_adc_range_sequencer;
   localparam int WC       = 8;
   localparam int SC       = 8;
   localparam int NS       = WC / 2;
   localparam int SCAN_LEN = WC * (SC + 2) + 1;

   typedef logic [15:0] words_t [WC];
   typedef struct {
      logic [15:0]   thr;
      words_t        d;
      logic [NS-1:0] alarms;
   } vec_t;

   logic          sysClk         = 1'b0;
   logic          sysReset       = 1'b1;
   logic          sysCsrStrobe   = 1'b0;
   logic [31:0]   GPIO_OUT       = '0;
   logic [31:0]   sysStatus;
   logic          rangeCsrStrobe;
   logic [31:0]   rangeGpioOut;
   logic [31:0]   rangeReadout;
   logic [2:0]    sysReadAddress = '0;
   logic [15:0]   sysReadData;
   logic [15:0]   alarmThreshold = '0;
   logic [NS-1:0] sysAlarms;

   adc_range_sequencer #(.WORD_COUNT(WC), .SETTLE_CYCLES(SC)) dut (
      .sysClk         (sysClk),
      .sysReset       (sysReset),
      .sysCsrStrobe   (sysCsrStrobe),
      .GPIO_OUT       (GPIO_OUT),
      .sysStatus      (sysStatus),
      .rangeCsrStrobe (rangeCsrStrobe),
      .rangeGpioOut   (rangeGpioOut),
      .rangeReadout   (rangeReadout),
      .sysReadAddress (sysReadAddress),
      .sysReadData    (sysReadData),
      .alarmThreshold (alarmThreshold),
      .sysAlarms      (sysAlarms)
   );

   always #5 sysClk = ~sysClk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge sysClk) cyc <= cyc + 1;

   // Range checker model: latch resets the word pointer, shift advances it.
   words_t     ckr_data;
   logic [2:0] ptr = '0;
   always @(posedge sysClk) if (rangeCsrStrobe) ptr <= rangeGpioOut[0] ? 3'd0 : ptr + 3'd1;
   assign rangeReadout = {16'hA5A5, ckr_data[ptr]};

   // Monitors: strobe timestamps/commands and DONE cycles (from count steps).
   int          strb_cyc[$];
   logic [31:0] strb_val[$];
   int          done_cyc[$];
   logic [15:0] prev_cnt    = '0;
   int          gpio_glitch = 0;
   always @(negedge sysClk) begin
      if (rangeCsrStrobe) begin
         strb_cyc.push_back(cyc);
         strb_val.push_back(rangeGpioOut);
      end else if (rangeGpioOut != 32'd0) begin
         gpio_glitch <= gpio_glitch + 1;
      end
      if (sysStatus[31:16] == prev_cnt + 16'd1) done_cyc.push_back(cyc - 1);
      prev_cnt <= sysStatus[31:16];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model state
   logic [15:0] exp_count = '0;
   logic        exp_front = 1'b0;
   words_t      model_front;

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge sysClk);
   endtask

   task automatic csr(input logic [31:0] d);
      sysCsrStrobe = 1'b1;
      GPIO_OUT     = d;
      nclk(1);
      sysCsrStrobe = 1'b0;
      GPIO_OUT     = '0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (sysStatus[0] && n < budget) begin
         nclk(1);
         n++;
      end
      chk_eq({tag, "_idle"}, {31'd0, sysStatus[0]}, 32'd0);
   endtask

   task automatic model_scan(input words_t d);
      model_front = d;
      exp_count   = exp_count + 16'd1;
      exp_front   = ~exp_front;
   endtask

   task automatic run_scan(input words_t d, input string tag);
      ckr_data = d;
      csr(32'h1);
      wait_idle(SCAN_LEN + 20, tag);
      model_scan(d);
   endtask

   task automatic read_check(input string tag);
      for (int a = 0; a < WC; a++) begin
         sysReadAddress = 3'(a);
         nclk(1);
         chk_eq($sformatf("%s_rd%0d", tag, a), {16'd0, sysReadData}, {16'd0, model_front[a]});
      end
   endtask

   function automatic logic [31:0] exp_status(input logic periodic, input logic busy);
      return {exp_count, 13'd0, exp_front, periodic, busy};
   endfunction

   // Alarm rule from plain integer arithmetic on the captured words.
   function automatic logic [NS-1:0] ref_alarms(input words_t d, input logic [15:0] thr);
      logic [NS-1:0] r;
      int v;
      int t;
      r = '0;
      for (int k = 0; k < WC; k++) begin
         v = int'($signed(d[k]));
         t = int'({16'd0, thr});
         if ((k % 2 == 0) ? (v < -t) : (v > t)) r[k / 2] = 1'b1;
      end
      return r;
   endfunction

   int     n;
   words_t w;
   vec_t   tbl[5];

   initial begin
      tbl[0].thr = 16'h7000;
      tbl[0].d   = '{16'h0000, 16'h0100, 16'h0200, 16'h7FFF, 16'h8000, 16'h0500, 16'h0600, 16'h0700};
      tbl[0].alarms = 4'b0110;
      tbl[1].thr = 16'h0000;
      tbl[1].d   = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001};
      tbl[1].alarms = 4'b1001;
      tbl[2].thr = 16'hFFFF;
      tbl[2].d   = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
      tbl[2].alarms = 4'b0000;
      tbl[3].thr = 16'h7FFF;
      tbl[3].d   = '{16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 16'h8001, 16'h0000, 16'h0000, 16'h0000};
      tbl[3].alarms = 4'b0010;
      tbl[4].thr = 16'h0010;
      tbl[4].d   = '{16'hFFF0, 16'h0010, 16'hFFEF, 16'h0011, 16'h0000, 16'h0000, 16'h0011, 16'hFFEF};
      tbl[4].alarms = 4'b0010;

      // ---- reset state
      nclk(3);
      chk_eq("rst_status", sysStatus, 32'd0);
      chk_eq("rst_alarms", {28'd0, sysAlarms}, 32'd0);
      chk_eq("rst_strobe", {31'd0, rangeCsrStrobe}, 32'd0);
      chk_eq("rst_gpio", rangeGpioOut, 32'd0);
      chk_eq("rst_rdata", {16'd0, sysReadData}, 32'd0);
      sysReset = 1'b0;
      nclk(2);

      // ---- basic scan: word k = 0x0100*k
      for (int k = 0; k < WC; k++) w[k] = 16'(16'h0100 * k);
      alarmThreshold = 16'hFFFF;
      strb_cyc.delete(); strb_val.delete(); done_cyc.delete();
      ckr_data = w;
      csr(32'h1);
      chk_eq("basic_busy_req", {31'd0, sysStatus[0]}, 32'd1);
      chk_eq("basic_strobe_req", {31'd0, rangeCsrStrobe}, 32'd1);
      wait_idle(SCAN_LEN + 20, "basic");
      model_scan(w);
      nclk(2);
      chk_eq("basic_nstrobe", strb_cyc.size(), WC);
      chk_eq("basic_ndone", done_cyc.size(), 1);
      if (strb_cyc.size() == WC && done_cyc.size() == 1) begin
         for (int i = 0; i < WC; i++)
            chk_eq($sformatf("basic_cmd%0d", i), strb_val[i], (i == 0) ? 32'd1 : 32'd2);
         for (int i = 1; i < WC; i++)
            chk_eq($sformatf("basic_gap%0d", i), strb_cyc[i] - strb_cyc[i-1], SC + 2);
         chk_eq("basic_scan_len", done_cyc[0] - strb_cyc[0] + 1, SCAN_LEN);
      end
      chk_eq("basic_status", sysStatus, exp_status(1'b0, 1'b0));
      sysReadAddress = 3'd5;
      nclk(1);
      chk_eq("basic_addr5", {16'd0, sysReadData}, 32'h0500);
      read_check("basic");

      // ---- table-driven alarm vectors
      for (int i = 0; i < 5; i++) begin
         alarmThreshold = tbl[i].thr;
         csr(32'h4);
         run_scan(tbl[i].d, $sformatf("tbl%0d", i));
         chk_eq($sformatf("tbl%0d_alarms", i), {28'd0, sysAlarms}, {28'd0, tbl[i].alarms});
         chk_eq($sformatf("tbl%0d_status", i), sysStatus, exp_status(1'b0, 1'b0));
         if (i == 0) read_check("tbl0");
         csr(32'h4);
         chk_eq($sformatf("tbl%0d_clear", i), {28'd0, sysAlarms}, 32'd0);
      end

      // ---- clear and set in the same cycle: set wins
      alarmThreshold = 16'h0000;
      for (int k = 0; k < WC; k++) w[k] = 16'h0000;
      w[0] = 16'hFFFF;
      csr(32'h4);
      ckr_data = w;
      csr(32'h1);
      nclk(SC + 1);               // now in the capture cycle of word 0
      csr(32'h4);
      wait_idle(SCAN_LEN + 20, "setwins");
      model_scan(w);
      chk_eq("setwins_alarms", {28'd0, sysAlarms}, 32'd1);
      csr(32'h4);
      chk_eq("setwins_clear", {28'd0, sysAlarms}, 32'd0);

      // ---- start while busy is ignored
      strb_cyc.delete(); strb_val.delete(); done_cyc.delete();
      ckr_data = tbl[0].d;
      csr(32'h1);
      nclk(20);
      csr(32'h1);
      nclk(3);
      csr(32'h1);
      wait_idle(SCAN_LEN + 20, "busystart");
      model_scan(tbl[0].d);
      nclk(30);
      chk_eq("busystart_nstrobe", strb_cyc.size(), WC);
      chk_eq("busystart_ndone", done_cyc.size(), 1);
      chk_eq("busystart_status", sysStatus, exp_status(1'b0, 1'b0));

      // ---- randomized scans against the reference model
      for (int r = 0; r < 8; r++) begin
         logic [15:0] thr;
         thr = (r < 3) ? 16'($urandom_range(0, 4)) : 16'($urandom);
         for (int k = 0; k < WC; k++) begin
            case ($urandom_range(0, 4))
               0:       w[k] = thr;
               1:       w[k] = 16'(-thr);
               2:       w[k] = thr + 16'd1;
               3:       w[k] = 16'(-thr) - 16'd1;
               default: w[k] = 16'($urandom);
            endcase
         end
         alarmThreshold = thr;
         csr(32'h4);
         run_scan(w, $sformatf("rnd%0d", r));
         chk_eq($sformatf("rnd%0d_alarms", r), {28'd0, sysAlarms}, {28'd0, ref_alarms(w, thr)});
         chk_eq($sformatf("rnd%0d_status", r), sysStatus, exp_status(1'b0, 1'b0));
         read_check($sformatf("rnd%0d", r));
      end

      // ---- periodic, period 100, disabled mid scan 2
      for (int k = 0; k < WC; k++) w[k] = 16'($urandom);
      ckr_data = w;
      strb_cyc.delete(); strb_val.delete(); done_cyc.delete();
      csr({24'd100, 8'h03});
      chk_eq("per_enable_bit", {31'd0, sysStatus[1]}, 32'd1);
      n = 0;
      while (strb_cyc.size() < WC + 1 && n < 400) begin nclk(1); n++; end
      chk_eq("per_second_req_seen", {31'd0, strb_cyc.size() >= WC + 1}, 32'd1);
      chk_eq("per_first_done_seen", {31'd0, done_cyc.size() >= 1}, 32'd1);
      if (strb_cyc.size() >= WC + 1 && done_cyc.size() >= 1)
         chk_eq("per_holdoff_gap", strb_cyc[WC] - done_cyc[0], 101);
      nclk(20);
      csr(32'h0);
      wait_idle(SCAN_LEN + 20, "per");
      model_scan(w);
      model_scan(w);
      nclk(150);
      chk_eq("per_ndone", done_cyc.size(), 2);
      chk_eq("per_nstrobe", strb_cyc.size(), 2 * WC);
      chk_eq("per_status", sysStatus, exp_status(1'b0, 1'b0));
      read_check("per");

      // ---- periodic disabled while in holdoff
      strb_cyc.delete(); strb_val.delete(); done_cyc.delete();
      csr({24'd50, 8'h03});
      n = 0;
      while (done_cyc.size() < 1 && n < 200) begin nclk(1); n++; end
      chk_eq("hold_done_seen", done_cyc.size(), 1);
      model_scan(w);
      nclk(5);
      csr(32'h0);
      chk_eq("hold_busy_still", {31'd0, sysStatus[0]}, 32'd1);
      nclk(1);
      chk_eq("hold_idle_next", {31'd0, sysStatus[0]}, 32'd0);
      nclk(80);
      chk_eq("hold_nstrobe", strb_cyc.size(), WC);
      chk_eq("hold_status", sysStatus, exp_status(1'b0, 1'b0));

      // ---- periodic with period 0: back-to-back scans
      strb_cyc.delete(); strb_val.delete(); done_cyc.delete();
      csr({24'd0, 8'h03});
      n = 0;
      while (strb_cyc.size() < WC + 1 && n < 300) begin nclk(1); n++; end
      csr(32'h0);
      wait_idle(SCAN_LEN + 20, "p0");
      model_scan(w);
      model_scan(w);
      nclk(3);
      chk_eq("p0_ndone", done_cyc.size(), 2);
      if (strb_cyc.size() >= WC + 1 && done_cyc.size() >= 1)
         chk_eq("p0_gap", strb_cyc[WC] - done_cyc[0], 1);
      chk_eq("p0_status", sysStatus, exp_status(1'b0, 1'b0));

      // ---- reset at capture of word 3; front must already be bank 0
      if (exp_front) run_scan(w, "prerst_align");
      read_check("prerst");
      for (int k = 0; k < WC; k++) w[k] = 16'($urandom);
      ckr_data = w;
      alarmThreshold = 16'h0000;
      csr(32'h1);
      nclk(3 * (SC + 2) + SC + 1);
      sysReset = 1'b1;
      nclk(1);
      chk_eq("midrst_status", sysStatus, 32'd0);
      chk_eq("midrst_strobe", {31'd0, rangeCsrStrobe}, 32'd0);
      chk_eq("midrst_gpio", rangeGpioOut, 32'd0);
      chk_eq("midrst_alarms", {28'd0, sysAlarms}, 32'd0);
      chk_eq("midrst_rdata", {16'd0, sysReadData}, 32'd0);
      sysReset = 1'b0;
      exp_count = '0;
      exp_front = 1'b0;
      nclk(2);
      read_check("postrst");

      // ---- scan count wraps 0xFFFF -> 0
      force dut.scan_count = 16'hFFFF;
      nclk(1);
      release dut.scan_count;
      exp_count = 16'hFFFF;
      nclk(1);
      chk_eq("wrap_preload", {16'd0, sysStatus[31:16]}, 32'h0000FFFF);
      run_scan(w, "wrap");
      chk_eq("wrap_count", {16'd0, sysStatus[31:16]}, 32'd0);
      chk_eq("wrap_status", sysStatus, exp_status(1'b0, 1'b0));

      chk_eq("gpio_outside_req", gpio_glitch, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
